pc_fetch_seq: RTL and testbench

Fetch sequencer for the single-issue core: owns the architectural PC register and sequences instruction fetches over a request/grant/response instruction-memory interface. It presents one fetched instruction at a time to decode with a valid/ready handshake. It accepts PC redirects from execute (taken branch, jal, jalr) at any time, discarding stale in-flight responses. It sits between the next-PC logic and the instruction memory port, at most one request outstanding.

---
 rtl/pc_fetch_seq.sv | 86 ++++++++
 tb/tb_pc_fetch_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_seq.sv
// Fetch sequencer: owns the PC and issues one outstanding imem fetch at a time, presenting each word to decode.
// Zero-wait memory gives one instruction every 3 cycles; a redirect reaches imem_addr next cycle unless a stale response must drain.
module pc_fetch_seq #(
  parameter int CPU_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC = CPU_WIDTH'(32'h8000_0000)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  output logic [CPU_WIDTH-1:0] imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [31:0]          imem_rdata,
  output logic                 inst_valid,
  output logic [31:0]          inst_data,
  output logic [CPU_WIDTH-1:0] inst_pc,
  input  logic                 inst_ready,
  input  logic                 redirect_valid,
  input  logic [CPU_WIDTH-1:0] redirect_pc
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] FLUSH = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [CPU_WIDTH-1:0] pc_q, pc_d;
  logic                 capture;

  assign imem_req   = (state_q == REQ);
  assign imem_addr  = pc_q;
  assign inst_valid = (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    capture = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // A fetch granted alongside a redirect is already stale.
        if (imem_gnt) state_d = redirect_valid ? FLUSH : WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (redirect_valid) begin
            state_d = REQ;
          end else begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end else if (redirect_valid) begin
          state_d = FLUSH;
        end
      end
      HOLD: begin
        if (inst_ready) pc_d = pc_q + CPU_WIDTH'(4);
        if (inst_ready || redirect_valid) state_d = REQ;
      end
      FLUSH: begin
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) pc_d = redirect_pc & ~CPU_WIDTH'(3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_data <= '0;
      inst_pc   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (capture) begin
        inst_data <= imem_rdata;
        inst_pc   <= pc_q;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Bench for pc_fetch_seq: directed per-cycle vector table, async reset sequence, then random traffic vs a PC-sequence model.
module tb_pc_fetch_seq;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] I0 = 32'h1111_0001, I1 = 32'h2222_0002, I2 = 32'h3333_0003;
  localparam logic [31:0] I3 = 32'h4444_0004, I4 = 32'h5555_0005, I5 = 32'h6666_0006;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  int n_cmp = 0;
  int n_err = 0;

  pc_fetch_seq #(.CPU_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        ready, redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic g, input logic rv, input logic [31:0] rd,
                             input logic rdy, input logic rr, input logic [31:0] rp,
                             input logic er, input logic [31:0] ea,
                             input logic ev, input logic [31:0] ep, input logic [31:0] ed);
    vec_t r;
    r.gnt = g; r.rvalid = rv; r.rdata = rd; r.ready = rdy; r.redir = rr; r.rpc = rp;
    r.e_req = er; r.e_addr = ea; r.e_valid = ev; r.e_pc = ep; r.e_data = ed;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_9E17;
  endfunction

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic rr, input logic [31:0] rp);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    inst_ready = rdy; redirect_valid = rr; redirect_pc = rp;
  endtask

  // Random-phase model state: architectural PC and a one-deep memory pipeline.
  logic [31:0] exp_pc;
  bit          pend;
  int          lat;
  logic [31:0] pdata;
  bit          prev_hold;
  logic [31:0] prev_pc, prev_data;
  int          n_hs;

  initial begin
    // Outputs expected at each falling edge, then inputs for the following rising edge.
    vecs.push_back(v(0,0,0,      0,0,0,            0,0,            0,0,0));
    vecs.push_back(v(1,0,0,      0,0,0,            1,32'h8000_0000,0,0,0));
    vecs.push_back(v(0,1,I0,     1,0,0,            0,0,            0,0,0));
    vecs.push_back(v(0,0,0,      1,0,0,            0,0,            1,32'h8000_0000,I0));
    vecs.push_back(v(1,0,0,      1,0,0,            1,32'h8000_0004,0,0,0));
    vecs.push_back(v(0,1,I1,     1,0,0,            0,0,            0,0,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(v(0,0,0,    0,0,0,            0,0,            1,32'h8000_0004,I1));
    vecs.push_back(v(0,0,0,      1,0,0,            0,0,            1,32'h8000_0004,I1));
    vecs.push_back(v(0,0,0,      0,0,0,            1,32'h8000_0008,0,0,0));
    vecs.push_back(v(0,0,0,      0,1,32'h8000_0103,1,32'h8000_0008,0,0,0));
    vecs.push_back(v(0,0,0,      0,0,0,            1,32'h8000_0100,0,0,0));
    vecs.push_back(v(1,0,0,      0,0,0,            1,32'h8000_0100,0,0,0));
    vecs.push_back(v(0,1,I2,     0,0,0,            0,0,            0,0,0));
    vecs.push_back(v(0,0,0,      1,1,32'h8000_0040,0,0,            1,32'h8000_0100,I2));
    vecs.push_back(v(1,0,0,      0,0,0,            1,32'h8000_0040,0,0,0));
    vecs.push_back(v(0,0,0,      0,1,32'h8000_0200,0,0,            0,0,0));
    vecs.push_back(v(0,0,0,      0,0,0,            0,0,            0,0,0));
    vecs.push_back(v(0,1,32'hDEAD_BEEF,0,0,0,      0,0,            0,0,0));
    vecs.push_back(v(1,0,0,      0,0,0,            1,32'h8000_0200,0,0,0));
    vecs.push_back(v(0,1,I3,     0,1,32'h8000_0300,0,0,            0,0,0));
    vecs.push_back(v(1,0,0,      0,0,0,            1,32'h8000_0300,0,0,0));
    vecs.push_back(v(0,1,I4,     0,0,0,            0,0,            0,0,0));
    vecs.push_back(v(0,0,0,      0,1,32'hFFFF_FFFF,0,0,            1,32'h8000_0300,I4));
    vecs.push_back(v(1,0,0,      0,0,0,            1,32'hFFFF_FFFC,0,0,0));
    vecs.push_back(v(0,1,I5,     0,0,0,            0,0,            0,0,0));
    vecs.push_back(v(0,0,0,      1,0,0,            0,0,            1,32'hFFFF_FFFC,I5));
    vecs.push_back(v(1,0,0,      0,0,0,            1,32'h0000_0000,0,0,0));
    vecs.push_back(v(0,0,0,      0,0,0,            0,0,            0,0,0));

    repeat (3) @(negedge clk);
    chk("reset_req", {31'b0, imem_req}, 32'd0);
    chk("reset_valid", {31'b0, inst_valid}, 32'd0);
    chk("reset_data", inst_data, 32'd0);
    chk("reset_pc", inst_pc, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      chk($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
      if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].e_valid});
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].e_pc);
        chk($sformatf("v%0d_inst_data", i), inst_data, vecs[i].e_data);
      end
      drive(vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of an outstanding fetch.
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", {31'b0, imem_req}, 32'd0);
    chk("async_valid", {31'b0, inst_valid}, 32'd0);
    chk("async_data", inst_data, 32'd0);
    chk("async_pc", inst_pc, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_req", {31'b0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, RST_PC);

    // Random traffic: every fetch address and every accepted instruction is checked against the PC sequence.
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = RST_PC; pend = 0; lat = 0; pdata = '0; prev_hold = 0; prev_pc = '0; prev_data = '0; n_hs = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic g, rv, rdy, rr;
      logic [31:0] rd, rp;
      if (prev_hold) begin
        chk("stall_valid", {31'b0, inst_valid}, 32'd1);
        chk("stall_pc", inst_pc, prev_pc);
        chk("stall_data", inst_data, prev_data);
      end
      if (imem_req) chk("rand_addr", imem_addr, exp_pc);
      rv = 0; rd = $urandom;
      if (pend) begin
        if (lat == 0) begin rv = 1; rd = pdata; pend = 0; end
        else lat--;
      end
      g = imem_req && ($urandom_range(0, 2) != 0);
      if (g) begin
        pend = 1; lat = $urandom_range(0, 2); pdata = mem_word(imem_addr);
      end
      rdy = ($urandom_range(0, 3) != 0);
      rr  = ($urandom_range(0, 15) == 0);
      rp  = $urandom;
      if (inst_valid && rdy) begin
        chk("rand_inst_pc", inst_pc, exp_pc);
        chk("rand_inst_data", inst_data, mem_word(inst_pc));
        exp_pc = exp_pc + 32'd4;
        n_hs++;
      end
      if (rr) exp_pc = rp & ~32'd3;
      prev_hold = inst_valid && !rdy && !rr;
      prev_pc = inst_pc; prev_data = inst_data;
      drive(g, rv, rd, rdy, rr, rp);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("rand_progress", {31'b0, n_hs >= 200}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
